superalu_muldiv_responder: RTL and testbench
============================================

Name: superalu_muldiv_responder

Overview:
Responder side of the super-ALU start/done command interface. It samples operands, alu_type and mode_type on a rising alu_start, then runs an iterative multiply or restoring divide. It returns the result on FOUT with a sticky alu_is_done. It sits behind SA/CF controllers as a compact multiply/divide engine; the sqrt/CORDIC type is not served and is answered with an error.

Parameters:
MULTIPLICAND_WIDTH, 9, multiplicand bits taken from X_IN
MULTIPLIER_WIDTH, 8, multiplier bits taken from Y_IN
MULTIPLICATION_WIDTH, 12, product width placed on FOUT
DIVIDEND_WIDTH, 12, dividend bits taken from X_IN (divisor uses the same width from Y_IN)
QUOTIENT_WIDTH, 9, quotient width placed on FOUT
MAX_WIDTH, 13, width of X_IN, Y_IN and FOUT

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  reset, asynchronous, active-high
X_IN  in  MAX_WIDTH  multiplicand / dividend
Y_IN  in  MAX_WIDTH  multiplier / divisor
alu_start  in  1  level request; a new command launches on its rising edge
alu_type  in  4  [3]=multiply, [2]=divide, [1]=sqrt, [0]=reserved
mode_type  in  2  scaling mode
FOUT  out  MAX_WIDTH  result, zero-extended
alu_is_done  out  1  result valid; sticky
alu_err  out  1  divide-by-zero, saturation, or unsupported type

Behaviour:
- Reset (asynchronous, any state): state=IDLE; FOUT=0; alu_is_done=0; alu_err=0; start_d=0.
- Launch: the edge where alu_start=1 and start_d=0 (edge E0).
  - Captures X_IN, Y_IN, mode_type and the type.
  - Type priority: [3] > [2] > [1]; [0] is ignored.
  - Clears alu_is_done and alu_err.
  - Inputs are don't-care after E0.
- FSM states: IDLE -> MUL | DIV | FIN; MUL/DIV -> FIN; FIN -> HOLD; HOLD -> IDLE when alu_start=0.
  - In HOLD, FOUT is stable and alu_is_done=1.
- Multiply:
  - A=X[8:0]; B=Y[7:0] for mode 00/10, B={1,Y[7:0]} for mode 01.
  - Shift-add: 9 iterations, LSB-first. Result = (A*B)>>8, truncated to 12 bits, in FOUT[11:0].
  - Mode 11 bypasses iteration: FOUT={A,1'b0}.
  - Mode 10 behaves as 00.
- Divide: restoring, 20 iterations over N = X[11:0] << k.
  - k=8 for mode 00/11, 7 for mode 01, 6 for mode 10.
  - Quotient > 511 -> FOUT[8:0]=511, alu_err=1.
  - Y[11:0]=0 -> no iteration, FOUT[8:0]=511, alu_err=1.
- Sqrt, or no type bit set: no operation; FOUT=0, alu_err=1.
- Latency (alu_is_done first high after edge):
  - Multiply mode 00/01/10: E0+10.
  - Multiply mode 11: E0+1.
  - Divide: E0+21.
  - Divide-by-zero, sqrt or no type: E0+1.
- FOUT and alu_is_done change together on the same edge; unused FOUT upper bits are 0.
- Done handshake:
  - alu_is_done stays 1 until alu_start is sampled 0; it drops on that edge.
  - FOUT holds its last result until the next completion.
- alu_start falling mid-operation: abort to IDLE on that edge. alu_is_done stays 0 and FOUT keeps its old value.
- alu_start held high across completion: no relaunch; a new command needs 0 then 1.
- Operands or mode changing mid-operation: no effect.
- Reset mid-operation: immediate return to reset values; no completion follows.

Optional Feature:
ALU_ROUND_EN
- Defined: round half-up.
  - Multiply adds 128 before >>8.
  - Divide increments the quotient when 2*remainder >= divisor, before the saturation check.
  - Latencies are unchanged.
- Undefined: truncation, as described above.

Test Plan:
- Multiply, mode 00, X=240, Y=0x6B -> FOUT=100 at E0+10; done held until alu_start=0. (Same result with ALU_ROUND_EN.)
- Multiply, mode 01, X=240, Y=0x6B -> FOUT=340. Then mode 11, X=7 -> FOUT=14 at E0+1.
- Divide:
  - 42/27, mode 01 -> 199.
  - 142/270, mode 10 -> 33 (34 with ALU_ROUND_EN).
  - 42/170, mode 00 -> 63.
  - 42/30, mode 00 -> 358.
  - All at E0+21 with alu_err=0.
- Divide, mode 00, X=42, Y=0 -> FOUT=511, alu_err=1 at E0+1. Then X=4000, Y=1 -> 511, alu_err=1.
- Control sequences:
  - alu_type=0010 -> FOUT=0, alu_err=1.
  - alu_start dropped at E0+5 of a multiply -> no done; FOUT keeps the prior value.
  - RST pulsed mid-divide -> all outputs 0 immediately.
- alu_start held high 40 cycles after done -> exactly one completion; 0->1 restart yields a second result.

Source files
------------

// File: rtl/superalu_muldiv_responder.sv
// superalu_muldiv_responder
//   Responder side of the super-ALU start/done command interface. A rising
//   alu_start launches a command: shift-add multiply (9 iterations) or
//   restoring divide (20 iterations). The sqrt type, or no type bit, is
//   answered with an error. The result is returned on FOUT with a sticky
//   alu_is_done that drops once alu_start is seen low.
//   Optional build macro ALU_ROUND_EN: round half-up instead of truncating.
// Ports:
//   CLK         system clock, rising edge
//   RST         asynchronous active-high reset
//   X_IN        multiplicand / dividend
//   Y_IN        multiplier / divisor
//   alu_start   level request, launches on its rising edge
//   alu_type    [3]=multiply [2]=divide [1]=sqrt [0]=reserved
//   mode_type   scaling mode
//   FOUT        result, zero-extended
//   alu_is_done result valid, sticky
//   alu_err     divide-by-zero, saturation or unsupported type
module superalu_muldiv_responder #(
   parameter int unsigned MULTIPLICAND_WIDTH   = 9,
   parameter int unsigned MULTIPLIER_WIDTH     = 8,
   parameter int unsigned MULTIPLICATION_WIDTH = 12,
   parameter int unsigned DIVIDEND_WIDTH       = 12,
   parameter int unsigned QUOTIENT_WIDTH       = 9,
   parameter int unsigned MAX_WIDTH            = 13
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [MAX_WIDTH-1:0] X_IN,
   input  logic [MAX_WIDTH-1:0] Y_IN,
   input  logic                 alu_start,
   input  logic [3:0]           alu_type,
   input  logic [1:0]           mode_type,
   output logic [MAX_WIDTH-1:0] FOUT,
   output logic                 alu_is_done,
   output logic                 alu_err
);

   localparam int unsigned MCW      = MULTIPLICAND_WIDTH;
   localparam int unsigned MRW      = MULTIPLIER_WIDTH;
   localparam int unsigned PW       = MCW + MRW + 1;
   localparam int unsigned MSW      = 8 + MULTIPLICATION_WIDTH;
   localparam int unsigned DW       = DIVIDEND_WIDTH;
   localparam int unsigned NW       = DW + 8;
   localparam int unsigned QW       = QUOTIENT_WIDTH;
   localparam int unsigned QMAX     = (1 << QW) - 1;
   localparam int unsigned MUL_ITER = MCW;
   localparam int unsigned DIV_ITER = NW;
`ifdef ALU_ROUND_EN
   localparam int unsigned RND_ADD  = 128;
`else
   localparam int unsigned RND_ADD  = 0;
`endif

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_MUL  = 3'd1;
   localparam logic [2:0] S_DIV  = 3'd2;
   localparam logic [2:0] S_FIN  = 3'd3;
   localparam logic [2:0] S_HOLD = 3'd4;

   localparam logic [1:0] OP_NONE = 2'd0;
   localparam logic [1:0] OP_MUL  = 2'd1;
   localparam logic [1:0] OP_DIV  = 2'd2;

   logic [2:0]           state, state_nx;
   logic                 start_d;
   logic                 launch;
   logic [1:0]           op_r;
   logic [4:0]           cnt;
   logic [PW-1:0]        prod, mcand;
   logic [MRW:0]         mplier;
   logic [NW-1:0]        num, num_init;
   logic [DW-1:0]        dvsr, rem, rem_nx;
   logic [DW:0]          rem_sh;
   logic                 fits;
   logic                 rnd_up;
   logic [MSW-1:0]       mul_sum;
   logic [NW:0]          q_fin;
   logic [MAX_WIDTH-1:0] res_r, fin_val;
   logic                 err_r, fin_err;
   logic                 unused_ok;

   assign launch    = alu_start & ~start_d;
   assign unused_ok = ^{X_IN[MAX_WIDTH-1:DW], Y_IN[MAX_WIDTH-1:DW], alu_type[0], mul_sum[7:0]};

   // Dividend pre-scaled by the mode-selected shift
   always_comb begin
      num_init = NW'(X_IN[DW-1:0]) << 8;
      case (mode_type)
         2'b01:   num_init = NW'(X_IN[DW-1:0]) << 7;
         2'b10:   num_init = NW'(X_IN[DW-1:0]) << 6;
         default: num_init = NW'(X_IN[DW-1:0]) << 8;
      endcase
   end

   // One restoring-divide step; the quotient bit shifts into num's LSB
   always_comb begin
      rem_sh = {rem, num[NW-1]};
      fits   = (rem_sh >= {1'b0, dvsr});
      rem_nx = fits ? DW'(rem_sh - {1'b0, dvsr}) : rem_sh[DW-1:0];
   end

   // Completion value: scaling, rounding and saturation
   always_comb begin
`ifdef ALU_ROUND_EN
      rnd_up = ({rem, 1'b0} >= {1'b0, dvsr});
`else
      rnd_up = 1'b0;
`endif
      mul_sum = MSW'(prod) + MSW'(RND_ADD);
      q_fin   = (NW+1)'(num) + (NW+1)'(rnd_up);
      fin_val = res_r;
      fin_err = err_r;
      case (op_r)
         OP_MUL: begin
            fin_val = MAX_WIDTH'(mul_sum[MSW-1:8]);
            fin_err = 1'b0;
         end
         OP_DIV: begin
            if (q_fin > (NW+1)'(QMAX)) begin
               fin_val = MAX_WIDTH'(QMAX);
               fin_err = 1'b1;
            end else begin
               fin_val = MAX_WIDTH'(q_fin[QW-1:0]);
               fin_err = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Next-state logic; alu_start low aborts any operation in flight
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (launch) begin
               if (alu_type[3])
                  state_nx = (mode_type == 2'b11) ? S_FIN : S_MUL;
               else if (alu_type[2])
                  state_nx = (Y_IN[DW-1:0] == '0) ? S_FIN : S_DIV;
               else
                  state_nx = S_FIN;
            end
         end
         S_MUL: begin
            if (!alu_start)                    state_nx = S_IDLE;
            else if (cnt == 5'(MUL_ITER - 1))  state_nx = S_FIN;
         end
         S_DIV: begin
            if (!alu_start)                    state_nx = S_IDLE;
            else if (cnt == 5'(DIV_ITER - 1))  state_nx = S_FIN;
         end
         S_FIN:   state_nx = alu_start ? S_HOLD : S_IDLE;
         S_HOLD:  if (!alu_start) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= S_IDLE;
         start_d <= 1'b0;
      end else begin
         state   <= state_nx;
         start_d <= alu_start;
      end
   end

   // Operand capture, iteration datapath and registered outputs
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         op_r        <= OP_NONE;
         cnt         <= '0;
         prod        <= '0;
         mcand       <= '0;
         mplier      <= '0;
         num         <= '0;
         rem         <= '0;
         dvsr        <= '0;
         res_r       <= '0;
         err_r       <= 1'b0;
         FOUT        <= '0;
         alu_is_done <= 1'b0;
         alu_err     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (launch) begin
                  alu_is_done <= 1'b0;
                  alu_err     <= 1'b0;
                  cnt         <= '0;
                  prod        <= '0;
                  mcand       <= PW'(X_IN[MCW-1:0]);
                  mplier      <= {(mode_type == 2'b01), Y_IN[MRW-1:0]};
                  num         <= num_init;
                  rem         <= '0;
                  dvsr        <= Y_IN[DW-1:0];
                  if (alu_type[3]) begin
                     // mode 11 bypasses iteration with a plain doubling
                     op_r  <= (mode_type == 2'b11) ? OP_NONE : OP_MUL;
                     res_r <= MAX_WIDTH'({X_IN[MCW-1:0], 1'b0});
                     err_r <= 1'b0;
                  end else if (alu_type[2]) begin
                     op_r  <= (Y_IN[DW-1:0] == '0) ? OP_NONE : OP_DIV;
                     res_r <= MAX_WIDTH'(QMAX);
                     err_r <= 1'b1;
                  end else begin
                     op_r  <= OP_NONE;
                     res_r <= '0;
                     err_r <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               cnt <= cnt + 5'd1;
               if (mplier[0]) prod <= prod + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
            end
            S_DIV: begin
               cnt <= cnt + 5'd1;
               rem <= rem_nx;
               num <= {num[NW-2:0], fits};
            end
            S_FIN: begin
               if (alu_start) begin
                  FOUT        <= fin_val;
                  alu_is_done <= 1'b1;
                  alu_err     <= fin_err;
               end
            end
            S_HOLD: begin
               if (!alu_start) alu_is_done <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_superalu_muldiv_responder.sv
// Testbench for superalu_muldiv_responder: directed test-plan commands,
// control sequences (abort, reset, held start) and randomized commands
// checked against an arithmetic reference model.
module tb_superalu_muldiv_responder;

   logic        CLK = 1'b0;
   logic        RST;
   logic [12:0] X_IN, Y_IN;
   logic        alu_start;
   logic [3:0]  alu_type;
   logic [1:0]  mode_type;
   logic [12:0] FOUT;
   logic        alu_is_done;
   logic        alu_err;

   int n_chk  = 0;
   int n_fail = 0;

`ifdef ALU_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   superalu_muldiv_responder dut (
      .CLK         (CLK),
      .RST         (RST),
      .X_IN        (X_IN),
      .Y_IN        (Y_IN),
      .alu_start   (alu_start),
      .alu_type    (alu_type),
      .mode_type   (mode_type),
      .FOUT        (FOUT),
      .alu_is_done (alu_is_done),
      .alu_err     (alu_err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: result, error flag and cycles from launch edge to done
   task automatic model(input logic [12:0] x, input logic [12:0] y, input logic [3:0] t,
                        input logic [1:0] m, output logic [12:0] v, output logic e,
                        output int lat);
      int unsigned a, b, d, nn, q, r;
      if (t[3]) begin
         a = 32'(x[8:0]);
         b = (m == 2'b01) ? 256 + 32'(y[7:0]) : 32'(y[7:0]);
         e = 1'b0;
         if (m == 2'b11) begin
            v = 13'(a * 2);
            lat = 1;
         end else begin
            v = 13'(((a * b + (RND ? 128 : 0)) >> 8) & 32'hFFF);
            lat = 10;
         end
      end else if (t[2]) begin
         d = 32'(y[11:0]);
         if (d == 0) begin
            v = 13'd511; e = 1'b1; lat = 1;
         end else begin
            nn = 32'(x[11:0]) * ((m == 2'b01) ? 128 : (m == 2'b10) ? 64 : 256);
            q = nn / d;
            r = nn % d;
            if (RND && (2 * r >= d)) q = q + 1;
            if (q > 511) begin v = 13'd511; e = 1'b1; end
            else begin v = 13'(q); e = 1'b0; end
            lat = 21;
         end
      end else begin
         v = 13'd0; e = 1'b1; lat = 1;
      end
   endtask

   // One full command: launch, wait for done, hold, release
   task automatic do_cmd(input logic [12:0] x, input logic [12:0] y, input logic [3:0] t,
                         input logic [1:0] m, input int hold, output logic [12:0] fo);
      logic [12:0] ev, prev;
      logic        ee;
      int          el, n;
      bit          moved, stable;
      model(x, y, t, m, ev, ee, el);
      @(negedge CLK);
      X_IN = x; Y_IN = y; alu_type = t; mode_type = m; alu_start = 1'b1;
      prev = FOUT;
      @(posedge CLK); #1;
      chk("launch_done_clr", alu_is_done, 0);
      chk("launch_err_clr", alu_err, 0);
      // operands are don't-care after launch
      X_IN = 13'($urandom); Y_IN = 13'($urandom);
      alu_type = 4'($urandom); mode_type = 2'($urandom);
      n = 0; moved = 0;
      while (alu_is_done !== 1'b1 && n < 60) begin
         @(posedge CLK); #1;
         n++;
         if (alu_is_done !== 1'b1 && FOUT !== prev) moved = 1;
      end
      chk("latency", n, el);
      chk("fout", FOUT, ev);
      chk("err", alu_err, ee);
      chk("fout_quiet_during_op", moved, 0);
      fo = FOUT;
      stable = 1;
      for (int i = 0; i < hold; i++) begin
         @(posedge CLK); #1;
         if (alu_is_done !== 1'b1 || FOUT !== ev || alu_err !== ee) stable = 0;
      end
      chk("hold_stable", stable, 1);
      @(negedge CLK); alu_start = 1'b0;
      @(posedge CLK); #1;
      chk("done_drop", alu_is_done, 0);
      chk("fout_keep", FOUT, ev);
   endtask

   initial begin
      logic [12:0] fo, last;
      logic [3:0]  rt;
      bit          seen;
      RST = 1'b1; alu_start = 1'b0; X_IN = '0; Y_IN = '0; alu_type = '0; mode_type = '0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_fout", FOUT, 0);
      chk("rst_done", alu_is_done, 0);
      chk("rst_err", alu_err, 0);
      @(negedge CLK); RST = 1'b0;

      // multiply
      do_cmd(13'd240, 13'h6B, 4'b1000, 2'b00, 3, fo);  chk("tp_mul00", fo, 100);
      do_cmd(13'd240, 13'h6B, 4'b1000, 2'b01, 2, fo);  chk("tp_mul01", fo, 340);
      do_cmd(13'd7,   13'h6B, 4'b1000, 2'b11, 2, fo);  chk("tp_mul11", fo, 14);
      do_cmd(13'd240, 13'h6B, 4'b1000, 2'b10, 1, fo);  chk("tp_mul10", fo, 100);
      // divide
      do_cmd(13'd42,  13'd27,  4'b0100, 2'b01, 1, fo); chk("tp_div_42_27", fo, 199);
      do_cmd(13'd142, 13'd270, 4'b0100, 2'b10, 1, fo); chk("tp_div_142_270", fo, RND ? 34 : 33);
      do_cmd(13'd42,  13'd170, 4'b0100, 2'b00, 1, fo); chk("tp_div_42_170", fo, 63);
      do_cmd(13'd42,  13'd30,  4'b0100, 2'b00, 1, fo); chk("tp_div_42_30", fo, 358);
      do_cmd(13'd42,  13'd0,   4'b0100, 2'b00, 1, fo); chk("tp_div_by_zero", fo, 511);
      do_cmd(13'd4000, 13'd1,  4'b0100, 2'b00, 1, fo); chk("tp_div_sat", fo, 511);
      // unsupported types and priority
      do_cmd(13'd42, 13'd5, 4'b0010, 2'b00, 1, fo);    chk("tp_sqrt", fo, 0);
      do_cmd(13'd42, 13'd5, 4'b0001, 2'b00, 1, fo);    chk("tp_reserved", fo, 0);
      do_cmd(13'd240, 13'h6B, 4'b1111, 2'b00, 1, fo);  chk("tp_prio_mul", fo, 100);
      do_cmd(13'd42, 13'd30, 4'b0111, 2'b00, 1, fo);   chk("tp_prio_div", fo, 358);
      last = fo;

      // abort: start dropped so that E0+5 samples it low
      @(negedge CLK);
      X_IN = 13'd240; Y_IN = 13'h6B; alu_type = 4'b1000; mode_type = 2'b00; alu_start = 1'b1;
      @(posedge CLK);
      repeat (4) @(posedge CLK);
      @(negedge CLK); alu_start = 1'b0;
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge CLK); #1;
         if (alu_is_done !== 1'b0 || FOUT !== last) seen = 1;
      end
      chk("abort_no_done", seen, 0);
      chk("abort_fout_kept", FOUT, 358);

      // reset pulsed mid-divide
      @(negedge CLK);
      X_IN = 13'd4000; Y_IN = 13'd3; alu_type = 4'b0100; alu_start = 1'b1;
      @(posedge CLK);
      repeat (8) @(posedge CLK);
      #3 RST = 1'b1;
      #1;
      chk("rst_mid_fout", FOUT, 0);
      chk("rst_mid_done", alu_is_done, 0);
      chk("rst_mid_err", alu_err, 0);
      alu_start = 1'b0;
      @(negedge CLK); RST = 1'b0;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge CLK); #1;
         if (alu_is_done !== 1'b0 || FOUT !== 13'd0) seen = 1;
      end
      chk("rst_no_completion", seen, 0);

      // start held high long after completion, then a clean restart
      do_cmd(13'd42, 13'd27, 4'b0100, 2'b01, 40, fo); chk("held_first", fo, 199);
      do_cmd(13'd7,  13'd0,  4'b1000, 2'b11, 2, fo);  chk("held_restart", fo, 14);

      // randomized commands against the model
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 3))
            0:       rt = 4'b1000;
            1:       rt = 4'b0100;
            2:       rt = 4'b0100;
            default: rt = 4'($urandom_range(0, 15));
         endcase
         do_cmd(13'($urandom),
                ($urandom_range(0, 1) == 1) ? 13'($urandom_range(0, 4095)) : 13'($urandom_range(0, 40)),
                rt, 2'($urandom), int'($urandom_range(0, 3)), fo);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
